seq_pattern_gen: RTL

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

---
 rtl/seq_pattern_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts out len bits MSB-first, rep+1 times,
// separated by GAP idle bit-times, then pulses done for one cycle.
module seq_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
  input  logic [3:0]       rep,
  output logic             data_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request sampled only in IDLE with len!=0; it is
  // accepted on that edge and the first bit appears the next cycle. done is a
  // single-cycle completion pulse; an aborted or reset transfer never pulses.

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [PAT_W-1:0]   pat_q;
  logic [3:0]         len_q;
  logic [3:0]         rep_q;
  logic [3:0]         bit_idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [3:0]         eff_len;

  assign dbg_state = state;

  // Lengths above PAT_W are clamped so the shifter never runs off the pattern.
  always_comb begin
    eff_len = len;
    if (int'(len) > PAT_W) eff_len = 4'(PAT_W);
  end

  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [3:0] idx);
    logic [PAT_W-1:0] s;
    s = p >> idx;
    return s[0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      data_out  <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pat_q     <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      bit_idx   <= '0;
      gap_cnt   <= '0;
    end else if (abort && (state == S_SHIFT || state == S_GAP)) begin
      state     <= S_IDLE;
      data_out  <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && len != 4'd0) begin
            state     <= S_SHIFT;
            pat_q     <= pattern;
            len_q     <= eff_len;
            rep_q     <= rep;
            bit_idx   <= eff_len - 4'd1;
            data_out  <= bit_at(pattern, eff_len - 4'd1);
            bit_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bit_idx != 4'd0) begin
            bit_idx  <= bit_idx - 4'd1;
            data_out <= bit_at(pat_q, bit_idx - 4'd1);
          end else if (rep_q != 4'd0) begin
            rep_q <= rep_q - 4'd1;
            if (GAP > 0) begin
              state     <= S_GAP;
              gap_cnt   <= GAP_W'(GAP - 1);
              data_out  <= 1'b0;
              bit_valid <= 1'b0;
            end else begin
              // Back-to-back repetition: reload straight into the top bit.
              bit_idx  <= len_q - 4'd1;
              data_out <= bit_at(pat_q, len_q - 4'd1);
            end
          end else begin
            state     <= S_DONE;
            data_out  <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state     <= S_SHIFT;
            bit_idx   <= len_q - 4'd1;
            data_out  <= bit_at(pat_q, len_q - 4'd1);
            bit_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          data_out  <= 1'b0;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
